usb_tx_line_encoder: RTL and testbench
======================================

# usb_tx_line_encoder

Serial line stage of the USB transmitter, directly downstream of the encode RCU and its parallel-to-serial shift register. It consumes one data bit per USB bit time and applies bit stuffing and NRZI encoding to drive the differential `d_plus`/`d_minus` pair. On request it generates the End-of-Packet sequence and reports completion to the RCU. It also returns the `bit_ready`, `byte_done` and `eop_done` handshakes that pace the RCU.

## Interface
- `CLKS_PER_BIT`, default 4: system clocks per USB bit time (48 MHz clock, 12 Mb/s full speed); legal values are 2 or more.
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  asynchronous active-low reset.
- `sending`  in  1  RCU requests packet data transmission.
- `selection`  in  1  RCU requests EOP generation.
- `tx_bit`  in  1  current serial data bit from the shift register, LSB first.
- `bit_ready`  out  1  1-clk pulse: `tx_bit` consumed this cycle, so the shifter advances.
- `byte_done`  out  1  1-clk pulse coincident with the `bit_ready` of every 8th data bit.
- `eop_done`  out  1  1-clk pulse after the EOP J bit completes.
- `tx_active`  out  1  high in every state except IDLE.
- `d_plus`  out  1  registered D+ line.
- `d_minus`  out  1  registered D- line.

## Operation
- States: IDLE, DATA, STUFF, SE0_1, SE0_2, EOP_J.
- Reset values: state IDLE; lines at J (`d_plus`=1, `d_minus`=0); `bit_ready`, `byte_done` and `eop_done` are 0; ones counter, bit counter and timer are 0.
- Bit timer: counts 0 to CLKS_PER_BIT-1 and wraps. `tick` = (timer == CLKS_PER_BIT-1). The timer is held at 0 in IDLE.
- IDLE: drives J. When `sending`=1, go to DATA and clear the ones counter and the 3-bit bit counter. When `selection`=1 with `sending`=0, go to SE0_1.
- DATA, on `tick`, in priority order:
  1. If the ones counter is 6 (stuff pending): go to STUFF. `bit_ready` is not pulsed.
  2. Else if `selection`=1: go to SE0_1.
  3. Else if `sending`=0: go to IDLE with the line at J.
  4. Else consume `tx_bit` and pulse `bit_ready`:
     - `tx_bit`=0: toggle the line and clear the ones counter.
     - `tx_bit`=1: hold the line and increment the ones counter.
     - Increment the bit counter. If it was 7, also pulse `byte_done`.
- STUFF: toggles the line at entry and clears the ones counter. On the next `tick`, re-evaluate exactly as in DATA (steps 2 to 4).
- NRZI: J = (1,0), K = (0,1). The encoded line level updates on the clock edge after `tick`.
- SE0_1 and SE0_2: each lasts one bit time with both lines at 0.
- EOP_J: lasts one bit time at J. At its `tick`, pulse `eop_done` and go to IDLE.
- `sending` and `selection` are sampled only on `tick` (or in IDLE). Changes between ticks are ignored.
- `n_rst` low at any time forces all reset values immediately, including mid-byte and mid-EOP. No `eop_done` is issued for an aborted EOP.

## Timing
- First data bit:
  - `bit_ready` for the first bit occurs CLKS_PER_BIT clocks after the IDLE to DATA transition.
  - The line changes 1 clock after each `bit_ready`.
- A data byte with no stuffing occupies exactly 8×CLKS_PER_BIT clocks.
- Each stuff bit adds CLKS_PER_BIT clocks and produces no `bit_ready`.
- EOP: 2×CLKS_PER_BIT clocks of SE0, then CLKS_PER_BIT clocks of J. `eop_done` is high for exactly 1 clock.
- All outputs are registered except `bit_ready`, `byte_done` and `eop_done`, which are decoded combinationally from state and `tick`.

## Configuration
- `USB_TX_BIT_STUFF_EN` defined: bit stuffing behaves as specified above.
- `USB_TX_BIT_STUFF_EN` undefined:
  - The ones counter and the STUFF state are not built.
  - A run of any length of 1s is sent unmodified.
  - This mode is for line-level debug only.

## Test plan
- Byte 0x80, `sending` held high, CLKS_PER_BIT=4 -> `bit_ready` every 4 clks, 8 pulses total. `d_plus` per bit = 0,1,0,1,0,1,0,0. `byte_done` coincides with the 8th `bit_ready`.
- Byte 0xFF, stuffing enabled -> line holds J for 6 bits, then a K stuff bit with no `bit_ready` for 4 clks. Bits 7 and 8 follow at K, and `byte_done` arrives 36 clks after the first slot start.
- Byte 0xFF, macro undefined -> 8 `bit_ready` pulses in 32 clks, line constant J, no stuff slot.
- `selection`=1 with `sending`=0 after a byte -> 8 clks of (0,0), then 4 clks of (1,0). `eop_done` pulses once, then `tx_active`=0.
- Six 1s, then `selection`=1 at the next `tick` -> stuff bit (line toggles) is sent first, then SE0_1. Exactly one `eop_done`.
- `n_rst` pulsed low in the middle of the 4th data bit -> lines return to (1,0) asynchronously and all pulses are 0. After release with `sending`=0, the block stays in IDLE.

Source files
------------

// File: rtl/usb_tx_line_encoder_if.sv
// usb_tx_line_encoder_if
// Handshake and line signals between the encode RCU/shifter and the USB
// serial line stage.
//   sending, selection, tx_bit       : RCU -> line stage
//   bit_ready, byte_done, eop_done   : line stage -> RCU pacing pulses
//   tx_active, d_plus, d_minus       : line stage status and differential pair
// modport master : RCU side
// modport slave  : line encoder side
interface usb_tx_line_encoder_if;
    logic sending;
    logic selection;
    logic tx_bit;
    logic bit_ready;
    logic byte_done;
    logic eop_done;
    logic tx_active;
    logic d_plus;
    logic d_minus;

    modport master (
        output sending, selection, tx_bit,
        input  bit_ready, byte_done, eop_done, tx_active, d_plus, d_minus
    );

    modport slave (
        input  sending, selection, tx_bit,
        output bit_ready, byte_done, eop_done, tx_active, d_plus, d_minus
    );
endinterface

// File: rtl/usb_tx_line_encoder.sv
// usb_tx_line_encoder
// Serial line stage of the USB transmitter: paces the shift register one bit
// per USB bit time, applies bit stuffing and NRZI, and generates EOP.
// Ports:
//   clk    : system clock, rising edge
//   n_rst  : asynchronous active-low reset
//   bus    : usb_tx_line_encoder_if.slave
//            in : sending, selection, tx_bit
//            out: bit_ready, byte_done, eop_done (combinational pulses)
//                 tx_active, d_plus, d_minus (registered)
// Parameter CLKS_PER_BIT (>= 2): system clocks per USB bit time.
// Build option: USB_TX_BIT_STUFF_EN enables the ones counter and STUFF state;
// without it runs of 1s go out unmodified (line-level debug only).
module usb_tx_line_encoder #(
    parameter int CLKS_PER_BIT = 4
) (
    input logic                  clk,
    input logic                  n_rst,
    usb_tx_line_encoder_if.slave bus
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        SE0_1,
        SE0_2,
        EOP_J
`ifdef USB_TX_BIT_STUFF_EN
        ,
        STUFF
`endif
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic          dp, dm, dp_n, dm_n;
    logic          active;
    logic          tick;
    logic          eval;
    logic          bit_ready, byte_done, eop_done;
`ifdef USB_TX_BIT_STUFF_EN
    logic [2:0]    ones, ones_n;
`endif

    // Timer only runs while a packet is on the wire; it wraps on tick so
    // every state boundary lands on timer == 0.
    assign tick = (timer == TMAX);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            dp      <= 1'b1;
            dm      <= 1'b0;
            active  <= 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
            ones    <= '0;
`endif
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_cnt <= bit_cnt_n;
            dp      <= dp_n;
            dm      <= dm_n;
            active  <= (state_n != IDLE);
`ifdef USB_TX_BIT_STUFF_EN
            ones    <= ones_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = (state == IDLE || tick) ? '0 : timer + 1'b1;
        bit_cnt_n = bit_cnt;
        dp_n      = dp;
        dm_n      = dm;
        eval      = 1'b0;
        bit_ready = 1'b0;
        byte_done = 1'b0;
        eop_done  = 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
        ones_n    = ones;
`endif

        case (state)
            IDLE: begin
                dp_n = 1'b1;
                dm_n = 1'b0;
                if (bus.sending) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
`ifdef USB_TX_BIT_STUFF_EN
                    ones_n    = '0;
`endif
                end else if (bus.selection) begin
                    state_n = SE0_1;
                    dp_n    = 1'b0;
                    dm_n    = 1'b0;
                end
            end
            DATA: begin
                if (tick) begin
`ifdef USB_TX_BIT_STUFF_EN
                    // A pending stuff bit outranks EOP and end-of-data, so a
                    // packet never ends on six unbroken 1s.
                    if (ones == 3'd6) begin
                        state_n = STUFF;
                        dp_n    = ~dp;
                        dm_n    = ~dm;
                        ones_n  = '0;
                    end else begin
                        eval = 1'b1;
                    end
`else
                    eval = 1'b1;
`endif
                end
            end
`ifdef USB_TX_BIT_STUFF_EN
            STUFF: begin
                if (tick) eval = 1'b1;
            end
`endif
            SE0_1: begin
                if (tick) state_n = SE0_2;
            end
            SE0_2: begin
                if (tick) begin
                    state_n = EOP_J;
                    dp_n    = 1'b1;
                    dm_n    = 1'b0;
                end
            end
            EOP_J: begin
                if (tick) begin
                    state_n  = IDLE;
                    eop_done = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                dp_n    = 1'b1;
                dm_n    = 1'b0;
            end
        endcase

        // Bit-time decision shared by DATA and the slot after a stuff bit.
        if (eval) begin
            if (bus.selection) begin
                state_n = SE0_1;
                dp_n    = 1'b0;
                dm_n    = 1'b0;
            end else if (!bus.sending) begin
                state_n = IDLE;
                dp_n    = 1'b1;
                dm_n    = 1'b0;
            end else begin
                state_n   = DATA;
                bit_ready = 1'b1;
                byte_done = (bit_cnt == 3'd7);
                bit_cnt_n = bit_cnt + 3'd1;
                if (!bus.tx_bit) begin
                    // NRZI: a 0 is a transition, a 1 holds the level.
                    dp_n = ~dp;
                    dm_n = ~dm;
`ifdef USB_TX_BIT_STUFF_EN
                    ones_n = '0;
                end else begin
                    ones_n = ones + 3'd1;
`endif
                end
            end
        end
    end

    assign bus.bit_ready = bit_ready;
    assign bus.byte_done = byte_done;
    assign bus.eop_done  = eop_done;
    assign bus.tx_active = active;
    assign bus.d_plus    = dp;
    assign bus.d_minus   = dm;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
module tb_usb_tx_line_encoder;

    localparam int CPB = 4;
    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;

    // One entry per bit-time decision, as seen from the wire.
    typedef enum int {D_BIT0, D_BIT1, D_STUFF, D_EOP, D_END, D_SE0A, D_SE0B, D_EOPJ} dec_t;

    logic clk;
    logic n_rst;
    int   vectors;
    int   miscompares;
    bit   bits_q[$];
    dec_t dq[$];

    usb_tx_line_encoder_if bus ();

    usb_tx_line_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input logic [1:0] line, input logic ta, input logic br,
                             input logic bd, input logic ed);
        check("lines",     {bus.d_plus, bus.d_minus}, line);
        check("tx_active", {1'b0, bus.tx_active},     {1'b0, ta});
        check("bit_ready", {1'b0, bus.bit_ready},     {1'b0, br});
        check("byte_done", {1'b0, bus.byte_done},     {1'b0, bd});
        check("eop_done",  {1'b0, bus.eop_done},      {1'b0, ed});
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) bits_q.push_back(b[i]);
    endtask

    // Reference: turn the bit stream into the list of bit-time decisions.
    task automatic build(input bit eop_only, input bit finish_eop);
        int ones;
        dq.delete();
        ones = 0;
        if (eop_only) begin
            dq.push_back(D_SE0A); dq.push_back(D_SE0B); dq.push_back(D_EOPJ);
            return;
        end
        foreach (bits_q[i]) begin
`ifdef USB_TX_BIT_STUFF_EN
            if (ones == 6) begin dq.push_back(D_STUFF); ones = 0; end
`endif
            dq.push_back(bits_q[i] ? D_BIT1 : D_BIT0);
            ones = bits_q[i] ? ones + 1 : 0;
        end
`ifdef USB_TX_BIT_STUFF_EN
        if (ones == 6) dq.push_back(D_STUFF);
`endif
        if (finish_eop) begin
            dq.push_back(D_EOP); dq.push_back(D_SE0A);
            dq.push_back(D_SE0B); dq.push_back(D_EOPJ);
        end else begin
            dq.push_back(D_END);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sending = 1'b0; bus.selection = 1'b0; bus.tx_bit = 1'($urandom);
            #1 check_all(LJ, 0, 0, 0, 0);
        end
    endtask

    // Replays dq against the DUT; inputs only matter on the tick cycle, so
    // every other cycle gets random garbage. abort_cyc >= 0 pulses reset there.
    task automatic run_packet(input bit eop_only, input int abort_cyc);
        logic [1:0] line;
        int nbits, cyc;
        bit tk, isb;
        @(negedge clk);
        bus.sending = !eop_only; bus.selection = eop_only; bus.tx_bit = 1'($urandom);
        #1 check_all(LJ, 0, 0, 0, 0);
        @(posedge clk);
        line = eop_only ? LSE0 : LJ;
        nbits = 0;
        cyc = 0;
        for (int k = 0; k < dq.size(); k++) begin
            for (int p = 0; p < CPB; p++) begin
                @(negedge clk);
                tk = (p == CPB - 1);
                bus.sending = 1'($urandom); bus.selection = 1'($urandom); bus.tx_bit = 1'($urandom);
                if (tk) begin
                    case (dq[k])
                        D_BIT0, D_BIT1: begin
                            bus.sending = 1'b1; bus.selection = 1'b0; bus.tx_bit = (dq[k] == D_BIT1);
                        end
                        D_EOP: bus.selection = 1'b1;
                        D_END: begin bus.sending = 1'b0; bus.selection = 1'b0; end
                        default: ;
                    endcase
                end
                if (cyc == abort_cyc) begin
                    #2 n_rst = 1'b0;
                    #1 check_all(LJ, 0, 0, 0, 0);
                    @(negedge clk);
                    bus.sending = 1'b0; bus.selection = 1'b0;
                    #1 check_all(LJ, 0, 0, 0, 0);
                    n_rst = 1'b1;
                    idle_cycles(2 * CPB);
                    return;
                end
                isb = (dq[k] == D_BIT0 || dq[k] == D_BIT1);
                #1 check_all(line, 1, tk && isb, tk && isb && (nbits % 8 == 7),
                             tk && dq[k] == D_EOPJ);
                if (tk) begin
                    case (dq[k])
                        D_BIT0, D_STUFF: line = (line == LJ) ? LK : LJ;
                        D_BIT1: ;
                        D_EOP, D_SE0A: line = LSE0;
                        default: line = LJ;
                    endcase
                    if (isb) nbits++;
                end
                cyc++;
            end
        end
        idle_cycles(2);
    endtask

    initial begin
        int nb;
        bit eo;
        clk = 1'b0;
        n_rst = 1'b0;
        vectors = 0;
        miscompares = 0;
        bus.sending = 1'b0; bus.selection = 1'b0; bus.tx_bit = 1'b0;

        #12 check_all(LJ, 0, 0, 0, 0);
        @(negedge clk);
        n_rst = 1'b1;
        idle_cycles(2);

        // 0x80 then drop sending: alternating line then a held bit
        bits_q.delete(); add_byte(8'h80); build(0, 0); run_packet(0, -1);
        // 0xFF: stuff slot after six 1s (no stuff without the build option)
        bits_q.delete(); add_byte(8'hFF); build(0, 0); run_packet(0, -1);
        // byte then EOP
        bits_q.delete(); add_byte(8'h80); build(0, 1); run_packet(0, -1);
        // six 1s then selection: stuff bit precedes SE0
        bits_q.delete(); for (int i = 0; i < 6; i++) bits_q.push_back(1'b1);
        build(0, 1); run_packet(0, -1);
        // EOP straight from IDLE
        build(1, 1); run_packet(1, -1);
        // reset in the middle of the 4th data bit, then stay idle
        bits_q.delete(); add_byte(8'h5A); build(0, 0); run_packet(0, 3 * CPB + 1);
        // reset in the middle of SE0_2: no eop_done may follow
        build(1, 1); run_packet(1, CPB + 1);

        for (int n = 0; n < 30; n++) begin
            bits_q.delete();
            nb = $urandom_range(0, 3);
            eo = 1'($urandom);
            for (int b = 0; b < nb; b++)
                add_byte(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            build(nb == 0, eo);
            run_packet(nb == 0, -1);
            idle_cycles($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
